unsigned_divider_multibit: RTL and testbench

Iterative unsigned integer divider that computes BITS_PER_CYCLE quotient bits per clock (radix 2^BITS_PER_CYCLE, restoring).
- Uses the requester-supplied CLZ values to skip leading iterations.
- Sits behind the divider side of unsigned_division_interface and serves the div/rem execution unit.
- Over the previous single-bit divider it adds parametrised width and radix, an abort (flush) input, and a ready output.

---
 rtl/unsigned_divider_multibit_pkg.sv | 34 +++
 rtl/div_radix_step.sv | 41 ++++
 rtl/unsigned_divider_multibit.sv | 140 ++++++++++++++
 tb/tb_unsigned_divider_multibit.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_divider_multibit_pkg.sv
// Shared types and sizing helpers for the multi-bit restoring divider.
// Also carries the requester/divider bundle typedefs of the division interface.
package unsigned_divider_multibit_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_BITS_PER_CYCLE = 2;
  localparam int DIV_CLZ_W = $clog2(DIV_DATA_WIDTH);

  function automatic int div_cnt_w(input int dw, input int bpc);
    return $clog2(dw / bpc) + 1;
  endfunction

  localparam int DIV_CNT_W =
    div_cnt_w(DIV_DATA_WIDTH, DIV_BITS_PER_CYCLE);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  typedef struct packed {
    logic [DIV_DATA_WIDTH-1:0] dividend;
    logic [DIV_CLZ_W-1:0]      dividend_CLZ;
    logic [DIV_DATA_WIDTH-1:0] divisor;
    logic [DIV_CLZ_W-1:0]      divisor_CLZ;
    logic                      divisor_is_zero;
  } div_req_t;

  typedef struct packed {
    logic [DIV_DATA_WIDTH-1:0] quotient;
    logic [DIV_DATA_WIDTH-1:0] remainder;
  } div_rsp_t;

endpackage

// File: rtl/div_radix_step.sv
// Combinational core: BITS_PER_CYCLE cascaded restoring division steps.
module div_radix_step #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [DATA_WIDTH-1:0]     i_pr,
  input  logic [DATA_WIDTH-1:0]     i_shift,
  input  logic [DATA_WIDTH-1:0]     i_divisor,
  output logic [DATA_WIDTH-1:0]     o_pr,
  output logic [DATA_WIDTH-1:0]     o_shift,
  output logic [BITS_PER_CYCLE-1:0] o_qbits
);

  logic [DATA_WIDTH:0]       v_t;
  logic [DATA_WIDTH-1:0]     v_pr;
  logic [DATA_WIDTH-1:0]     v_sh;
  logic [BITS_PER_CYCLE-1:0] v_q;

  // Partial remainder stays below the divisor, so DATA_WIDTH bits hold it
  // between steps; only the trial value needs the extra top bit.
  always_comb begin
    v_pr = i_pr;
    v_sh = i_shift;
    v_q  = '0;
    v_t  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      v_t  = {v_pr, v_sh[DATA_WIDTH-1]};
      v_sh = v_sh << 1;
      if (v_t >= {1'b0, i_divisor}) begin
        v_t = v_t - {1'b0, i_divisor};
        v_q[BITS_PER_CYCLE-1-i] = 1'b1;
      end
      v_pr = v_t[DATA_WIDTH-1:0];
    end
  end

  assign o_pr    = v_pr;
  assign o_shift = v_sh;
  assign o_qbits = v_q;

endmodule

// File: rtl/unsigned_divider_multibit.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divider with CLZ-based skip,
// abort and ready; owns the FSM, iteration counter and result registers.
module unsigned_divider_multibit
  import unsigned_divider_multibit_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DATA_WIDTH-1:0]         dividend,
  input  logic [$clog2(DATA_WIDTH)-1:0] dividend_CLZ,
  input  logic [DATA_WIDTH-1:0]         divisor,
  input  logic [$clog2(DATA_WIDTH)-1:0] divisor_CLZ,
  input  logic                          divisor_is_zero,
  output logic                          ready,
  output logic                          done,
  output logic [DATA_WIDTH-1:0]         quotient,
  output logic [DATA_WIDTH-1:0]         remainder
);

  localparam int CLZ_W   = $clog2(DATA_WIDTH);
  localparam int CNT_W   = div_cnt_w(DATA_WIDTH, BITS_PER_CYCLE);
  localparam int LOG_BPC = $clog2(BITS_PER_CYCLE);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4) ||
      (DATA_WIDTH % BITS_PER_CYCLE) != 0 ||
      DATA_WIDTH < 8) begin : g_bad_cfg
    $error("unsigned_divider_multibit: illegal BITS_PER_CYCLE/DATA_WIDTH");
  end

  div_state_e                r_state;
  logic                      r_done;
  logic [DATA_WIDTH-1:0]     r_pr;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_quot;
  logic [DATA_WIDTH-1:0]     r_divisor;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_accept;
  logic [CLZ_W:0]            w_q;
  logic [CLZ_W:0]            w_n;
  logic [CLZ_W:0]            w_p;
  logic [DATA_WIDTH-1:0]     w_pr_load;
  logic [DATA_WIDTH-1:0]     w_shift_load;
  logic [DATA_WIDTH-1:0]     w_pr_nxt;
  logic [DATA_WIDTH-1:0]     w_shift_nxt;
  logic [BITS_PER_CYCLE-1:0] w_qbits;

  assign w_accept = start & ~abort & (r_state == IDLE);

  // Significant quotient bits, rounded up to whole iterations; the
  // dividend is pre-shifted so only those P bits are ever processed.
  assign w_q = {1'b0, divisor_CLZ} - {1'b0, dividend_CLZ}
             + (CLZ_W+1)'(1);
  assign w_n = (w_q + (CLZ_W+1)'(BITS_PER_CYCLE - 1)) >> LOG_BPC;
  assign w_p = w_n << LOG_BPC;
  assign w_pr_load    = dividend >> w_p;
  assign w_shift_load =
    dividend << ((CLZ_W+1)'(DATA_WIDTH) - w_p);

  div_radix_step #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .i_pr     (r_pr),
    .i_shift  (r_shift),
    .i_divisor(r_divisor),
    .o_pr     (w_pr_nxt),
    .o_shift  (w_shift_nxt),
    .o_qbits  (w_qbits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_pr      <= '0;
      r_shift   <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (divisor_is_zero) begin
              r_quot <= '1;
              r_pr   <= dividend;
              r_done <= 1'b1;
            end else if (divisor_CLZ < dividend_CLZ) begin
              r_quot <= '0;
              r_pr   <= dividend;
              r_done <= 1'b1;
            end else begin
              r_pr      <= w_pr_load;
              r_shift   <= w_shift_load;
              r_quot    <= '0;
              r_divisor <= divisor;
              r_cnt     <= CNT_W'(w_n - (CLZ_W+1)'(1));
              r_state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_pr    <= w_pr_nxt;
            r_shift <= w_shift_nxt;
            r_quot  <= {r_quot[DATA_WIDTH-BITS_PER_CYCLE-1:0],
                        w_qbits};
            if (r_cnt == '0) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = (r_state == IDLE);
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_pr;

  ap_dz_consistent: assert property (
    @(posedge clk) disable iff (rst)
    (w_accept && divisor_is_zero) |-> (divisor == '0)
  ) else $error("divisor_is_zero set with nonzero divisor");

endmodule

// File: tb/tb_unsigned_divider_multibit.sv
// Bench: three divider instances (1, 2 and 4 bits/cycle) on shared inputs,
// checked against an arithmetic reference model of quotient, remainder, latency.
module tb_unsigned_divider_multibit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        dz;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [4:0]  dvd_clz;
  logic [4:0]  dvs_clz;
  logic [2:0]  rdy;
  logic [2:0]  dn;
  logic [31:0] qo [3];
  logic [31:0] ro [3];

  int checks = 0;
  int failures = 0;

  int          m_lat [3];
  int          m_pulses [3];
  logic [31:0] m_q [3];
  logic [31:0] m_r [3];
  logic [31:0] m_qe [3];
  logic [31:0] m_re [3];
  logic        m_rdy1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unsigned_divider_multibit #(
      .DATA_WIDTH    (32),
      .BITS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .dividend       (dvd),
      .dividend_CLZ   (dvd_clz),
      .divisor        (dvs),
      .divisor_CLZ    (dvs_clz),
      .divisor_is_zero(dz),
      .ready          (rdy[g]),
      .done           (dn[g]),
      .quotient       (qo[g]),
      .remainder      (ro[g])
    );
  end

  function automatic logic [4:0] clz32(input logic [31:0] x);
    for (int i = 31; i >= 0; i--)
      if (x[i]) return 5'(31 - i);
    return 5'd31;
  endfunction

  // Cycles from the start cycle to the done cycle, per the radix.
  function automatic int exp_lat(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input int k);
    int bpc, ca, cb, q;
    bpc = 1 << k;
    if (b == 0) return 1;
    ca = int'(clz32(a));
    cb = int'(clz32(b));
    if (cb < ca) return 1;
    q = cb - ca + 1;
    return (q + bpc - 1) / bpc + 1;
  endfunction

  function automatic logic [31:0] exp_q(input logic [31:0] a,
                                        input logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] exp_r(input logic [31:0] a,
                                        input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic set_req(input logic [31:0] a, input logic [31:0] b);
    dvd     = a;
    dvs     = b;
    dvd_clz = clz32(a);
    dvs_clz = clz32(b);
    dz      = (b == 0);
  endtask

  // Issue one request and record, per instance, the first done cycle,
  // the results at that cycle, the number of done pulses, and the
  // results one cycle after the last instance finished.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int tail;
    bit all;
    @(negedge clk);
    set_req(a, b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    set_req($urandom, $urandom);
    for (int k = 0; k < 3; k++) begin
      m_lat[k] = -1;
      m_pulses[k] = 0;
      m_q[k] = '0;
      m_r[k] = '0;
    end
    m_rdy1 = rdy[1];
    cyc = 1;
    tail = 0;
    while (cyc <= 60) begin
      for (int k = 0; k < 3; k++) begin
        if (dn[k] === 1'b1) begin
          m_pulses[k]++;
          if (m_lat[k] < 0) begin
            m_lat[k] = cyc;
            m_q[k] = qo[k];
            m_r[k] = ro[k];
          end
        end
      end
      all = (m_lat[0] >= 0) && (m_lat[1] >= 0) && (m_lat[2] >= 0);
      if (all && tail >= 1) break;
      if (all) tail++;
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      m_qe[k] = qo[k];
      m_re[k] = ro[k];
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || dn[k] !== 1'b0 ||
          qo[k] !== 32'd0 || ro[k] !== 32'd0) begin
        failures++;
        $display("FAIL reset%0d rdy=%b done=%b q=%h r=%h exp 1 0 0 0",
                 k, rdy[k], dn[k], qo[k], ro[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rdy !== 3'b111 || dn !== 3'b000) begin
      failures++;
      $display("FAIL post_reset rdy=%b done=%b exp 111 000", rdy, dn);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd100, 32'h1234, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'd7, 32'd0, 32'd9, 32'd1};
    logic [31:0] tq [4] = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] tr [4] = '{32'd2, 32'h1234, 32'd5, 32'd0};
    int          tl [4] = '{4, 1, 1, 17};
    for (int i = 0; i < 4; i++) begin
      do_div(ta[i], tb[i]);
      checks++;
      if (m_lat[1] !== tl[i]) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, m_lat[1], tl[i]);
      end
      checks++;
      if (m_q[1] !== tq[i] || m_r[1] !== tr[i]) begin
        failures++;
        $display("FAIL dir%0d_result q=%h r=%h exp q=%h r=%h",
                 i, m_q[1], m_r[1], tq[i], tr[i]);
      end
      checks++;
      if (m_pulses[1] !== 1) begin
        failures++;
        $display("FAIL dir%0d_pulses got=%0d exp=1", i, m_pulses[1]);
      end
      checks++;
      if (m_qe[1] !== tq[i] || m_re[1] !== tr[i]) begin
        failures++;
        $display("FAIL dir%0d_hold q=%h r=%h exp q=%h r=%h",
                 i, m_qe[1], m_re[1], tq[i], tr[i]);
      end
      checks++;
      if (m_rdy1 !== (tl[i] == 1)) begin
        failures++;
        $display("FAIL dir%0d_ready got=%b exp=%b", i, m_rdy1, tl[i] == 1);
      end
    end
    checks++;
    if (m_lat[0] !== 33 || m_lat[2] !== 9) begin
      failures++;
      $display("FAIL radix_latency bpc1=%0d bpc4=%0d exp 33 9",
               m_lat[0], m_lat[2]);
    end
    checks++;
    if (m_q[0] !== 32'hFFFF_FFFF || m_r[0] !== 0 ||
        m_q[2] !== 32'hFFFF_FFFF || m_r[2] !== 0) begin
      failures++;
      $display("FAIL radix_result q1=%h r1=%h q4=%h r4=%h exp ffffffff 0",
               m_q[0], m_r[0], m_q[2], m_r[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 40; n++) begin
      a = $urandom >> $urandom_range(0, 31);
      if (a == 0) a = 32'd1;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      do_div(a, b);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (m_lat[k] !== exp_lat(a, b, k)) begin
          failures++;
          $display("FAIL rnd_latency dut%0d %h/%h got=%0d exp=%0d",
                   k, a, b, m_lat[k], exp_lat(a, b, k));
        end
        checks++;
        if (m_q[k] !== exp_q(a, b) || m_r[k] !== exp_r(a, b)) begin
          failures++;
          $display("FAIL rnd_result dut%0d %h/%h q=%h r=%h exp q=%h r=%h",
                   k, a, b, m_q[k], m_r[k], exp_q(a, b), exp_r(a, b));
        end
        checks++;
        if (m_pulses[k] !== 1) begin
          failures++;
          $display("FAIL rnd_pulses dut%0d got=%0d exp=1", k, m_pulses[k]);
        end
        checks++;
        if (m_qe[k] !== exp_q(a, b) || m_re[k] !== exp_r(a, b)) begin
          failures++;
          $display("FAIL rnd_hold dut%0d q=%h r=%h exp q=%h r=%h",
                   k, m_qe[k], m_re[k], exp_q(a, b), exp_r(a, b));
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [2:0] seen;
    @(negedge clk);
    set_req(32'd100, 32'd7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (rdy !== 3'b111 || dn !== 3'b000) begin
      failures++;
      $display("FAIL abort_idle rdy=%b done=%b exp 111 000", rdy, dn);
    end
    seen = '0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= dn;
    end
    checks++;
    if (seen !== 3'b000) begin
      failures++;
      $display("FAIL abort_nodone seen=%b exp 000", seen);
    end
    @(negedge clk);
    set_req(32'd50, 32'd3);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (rdy !== 3'b111 || dn !== 3'b000) begin
      failures++;
      $display("FAIL abort_with_start rdy=%b done=%b exp 111 000", rdy, dn);
    end
    do_div(32'd200, 32'd9);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_lat[k] !== exp_lat(200, 9, k) ||
          m_q[k] !== 32'd22 || m_r[k] !== 32'd2) begin
        failures++;
        $display("FAIL post_abort dut%0d lat=%0d q=%0d r=%0d exp %0d 22 2",
                 k, m_lat[k], m_q[k], m_r[k], exp_lat(200, 9, k));
      end
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge clk);
    set_req(32'd1000, 32'd10);
    start = 1'b1;
    @(posedge clk);
    #1;
    set_req(32'd77, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 4;
    while (dn[1] !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 5 || qo[1] !== 32'd100 || ro[1] !== 32'd0) begin
      failures++;
      $display("FAIL busy_start lat=%0d q=%0d r=%0d exp 5 100 0",
               cyc, qo[1], ro[1]);
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    set_req(32'd100, 32'd7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (dn[1] !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4 || qo[1] !== 32'd14 || ro[1] !== 32'd2) begin
      failures++;
      $display("FAIL b2b_first lat=%0d q=%0d r=%0d exp 4 14 2",
               cyc, qo[1], ro[1]);
    end
    @(negedge clk);
    set_req(32'd1000, 32'd10);
    start = 1'b1;
    checks++;
    if (dn[1] !== 1'b1 || rdy[1] !== 1'b1 ||
        qo[1] !== 32'd14 || ro[1] !== 32'd2) begin
      failures++;
      $display("FAIL b2b_hold done=%b rdy=%b q=%0d r=%0d exp 1 1 14 2",
               dn[1], rdy[1], qo[1], ro[1]);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    checks++;
    if (dn[1] !== 1'b0 || rdy[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept done=%b rdy=%b exp 0 0", dn[1], rdy[1]);
    end
    while (dn[1] !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 5 || qo[1] !== 32'd100 || ro[1] !== 32'd0) begin
      failures++;
      $display("FAIL b2b_second lat=%0d q=%0d r=%0d exp 5 100 0",
               cyc, qo[1], ro[1]);
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_async_reset();
    logic [2:0] seen;
    @(negedge clk);
    set_req(32'hFFFF_FFFF, 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || dn[k] !== 1'b0 ||
          qo[k] !== 32'd0 || ro[k] !== 32'd0) begin
        failures++;
        $display("FAIL async_rst%0d rdy=%b done=%b q=%h r=%h exp 1 0 0 0",
                 k, rdy[k], dn[k], qo[k], ro[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    seen = '0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= dn;
    end
    checks++;
    if (seen !== 3'b000 || rdy !== 3'b111) begin
      failures++;
      $display("FAIL async_rst_quiet done_seen=%b rdy=%b exp 000 111",
               seen, rdy);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_req(32'd0, 32'd1);
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_busy_start();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
